// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 raster constants
//
// Default horizontal/vertical timing for the 640x480 mode, shared by the
// timing generator and by the colour/paddle logic that needs the visible
// window bounds. No ports.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int VGA_CLK_DIV     = 4;

  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_VIS_START = 144;
  localparam int VGA_H_VIS_END   = 783;

  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_VIS_START = 35;
  localparam int VGA_V_VIS_END   = 514;

endpackage

// File: rtl/pixel_strobe_gen.sv
// rtl/pixel_strobe_gen.sv - system-clock to pixel-rate strobe divider
//
// Counts 0..CLK_DIV-1 and raises pix_en_o on the last clk of every pixel
// period. pix_en_o is gated by the reset input so it is never high while
// reset is asserted, even when CLK_DIV is 1.
//
// Ports:
//   clk_i    - system clock
//   rst_ni   - synchronous active-low reset
//   pix_en_o - one-clk strobe on the last clk of each pixel period
module pixel_strobe_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic pix_en_o
);

  // Four bits cover the whole legal divide range 1..16.
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_q;
  logic [3:0] div_d;

  always_comb begin
    div_d = div_q + 4'd1;
    if (div_q == DIV_LAST) begin
      div_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q <= 4'd0;
    end else begin
      div_q <= div_d;
    end
  end

  assign pix_en_o = rst_ni && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with sync/visible decode
//
// Horizontal/vertical raster counters advanced by a pixel-rate strobe, with
// zero-latency combinational decode of sync and visible-window signals, plus
// a one-clk frame_tick on the (last,last) -> (0,0) wrap.
//
// Ports:
//   clk        - system clock (100 MHz)
//   rst        - synchronous active-low reset
//   hCount     - horizontal pixel position, 0..H_TOTAL-1
//   vCount     - line position, 0..V_TOTAL-1
//   hSync      - horizontal sync, active low
//   vSync      - vertical sync, active low
//   bright     - high inside the visible window
//   pix_en     - one-clk strobe on the last clk of each pixel period
//   frame_tick - one-clk pulse on the clk where the raster wraps to (0,0)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_VIS_START = VGA_H_VIS_START,
  parameter int H_VIS_END   = VGA_H_VIS_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_VIS_START = VGA_V_VIS_START,
  parameter int V_VIS_END   = VGA_V_VIS_END
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_en,
  output logic       frame_tick
);

  localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_SYN   = cnt_t'(H_SYNC);
  localparam cnt_t V_SYN   = cnt_t'(V_SYNC);
  localparam cnt_t H_VIS_L = cnt_t'(H_VIS_START);
  localparam cnt_t H_VIS_H = cnt_t'(H_VIS_END);
  localparam cnt_t V_VIS_L = cnt_t'(V_VIS_START);
  localparam cnt_t V_VIS_H = cnt_t'(V_VIS_END);

  logic pix_en_w;
  cnt_t hcount_q, hcount_d;
  cnt_t vcount_q, vcount_d;
  logic h_last_w, v_last_w;

  pixel_strobe_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_strobe_gen (
    .clk_i    (clk),
    .rst_ni   (rst),
    .pix_en_o (pix_en_w)
  );

  assign h_last_w = (hcount_q == H_LAST);
  assign v_last_w = (vcount_q == V_LAST);

  // The vertical counter only moves on the horizontal wrap.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en_w) begin
      if (h_last_w) begin
        hcount_d = '0;
        vcount_d = v_last_w ? '0 : vcount_q + cnt_t'(1);
      end else begin
        hcount_d = hcount_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hCount     = hcount_q;
  assign vCount     = vcount_q;
  assign pix_en     = pix_en_w;
  // pix_en_w is already low during reset, so no partial-frame tick can leak.
  assign frame_tick = pix_en_w && h_last_w && v_last_w;

  // Decoded straight from the count registers so they stay cycle-aligned.
  assign hSync  = (hcount_q >= H_SYN);
  assign vSync  = (vcount_q >= V_SYN);
  assign bright = (hcount_q >= H_VIS_L) && (hcount_q <= H_VIS_H) &&
                  (vcount_q >= V_VIS_L) && (vcount_q <= V_VIS_H);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing for the pong display on the Nexys4 100 MHz clock. It produces hCount, vCount and bright for the pixel/colour logic, and hSync and vSync for the VGA connector. It also emits a one-clock frame_tick so game-state logic such as paddle movement can update once per frame instead of every clock. It is the producer of the counter/bright interface that the colour-mapping block consumes.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); legal range 1..16
H_TOTAL, 800, pixels per line (hCount range 0..799)
H_SYNC, 96, hSync low for hCount 0..H_SYNC-1
H_VIS_START, 144, first visible column
H_VIS_END, 783, last visible column, inclusive
V_TOTAL, 525, lines per frame (vCount range 0..524)
V_SYNC, 2, vSync low for vCount 0..V_SYNC-1
V_VIS_START, 35, first visible line
V_VIS_END, 514, last visible line, inclusive

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk
hCount  out  10  current horizontal pixel position
vCount  out  10  current line position
hSync  out  1  horizontal sync, active low
vSync  out  1  vertical sync, active low
bright  out  1  high when the pixel is in the visible 640x480 window
pix_en  out  1  one-clk strobe marking the last clk of each pixel period
frame_tick  out  1  one-clk pulse on the clk where the raster wraps from (799,524) to (0,0)

Behaviour:
- Reset (rst==0 at a clk edge): div counter=0, hCount=0, vCount=0. pix_en=0 and frame_tick=0 while rst is low, including when CLK_DIV=1. hSync=0, vSync=0, bright=0 (decoded from 0,0). Reset overrides every other event.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = rst && (div==CLK_DIV-1). With CLK_DIV=1, pix_en is high on every clk after reset.
- Horizontal counter: on a clk edge with pix_en=1, hCount increments. At hCount==H_TOTAL-1 it wraps to 0 and vCount advances.
- Vertical counter: advances only on the hCount wrap. At vCount==V_TOTAL-1 it wraps to 0.
- frame_tick = pix_en && hCount==H_TOTAL-1 && vCount==V_TOTAL-1, asserted in the same cycle as the wrapping strobe. It produces exactly one pulse per frame.
- hCount and vCount are registers. hSync, vSync and bright are combinational decodes of those registers, so they carry zero latency and stay aligned with the counts.
  - hSync = (hCount >= H_SYNC)
  - vSync = (vCount >= V_SYNC)
  - bright = H_VIS_START<=hCount<=H_VIS_END && V_VIS_START<=vCount<=V_VIS_END
- Latency: after rst is released, hCount holds 0 for CLK_DIV clks, then steps every CLK_DIV clks.
  - One line = H_TOTAL*CLK_DIV clk = 3200.
  - One frame = 1,680,000 clk.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Widths are fixed at 10 bits; parameters must keep totals at or below 1024.
- Reset asserted mid-frame returns all state to the reset values on that edge. Counting restarts from (0,0) with no partial-frame frame_tick.

Decomposition:
- Package vga_timing_pkg holds the 640x480 constants (H_*/V_* defaults) so the colour and paddle logic share the visible-window bounds.
- One sub-module, pixel_strobe_gen, contains the CLK_DIV divider with a synchronous active-low reset. It outputs pix_en.
- The raster counters and sync/bright decode live in vga_timing_gen.

Test Plan:
1. Reset/strobe: hold rst=0 for 5 clks, then release. Expect hCount=vCount=0, hSync=vSync=bright=0 and pix_en=0 during reset. The first pix_en is on the 4th clk after release, and hCount=1 on the 5th.
2. Line timing: run 1 line. Expect hSync low for exactly 384 clk (hCount 0..95), hCount wrap 799->0 after 3200 clk, and vCount 0->1 on the same edge.
3. Visible window: sweep a full frame. Expect bright high exactly 640*480 pixel periods, first at (144,35) and last at (783,514), and low at (143,35), (784,35) and (144,515).
4. Frame wrap: run 2 frames. Expect frame_tick pulses exactly 1,680,000 clk apart, each one clk wide and coincident with the (799,524)->(0,0) transition. vSync is low for 2 lines (6400 clk) per frame.
5. Mid-frame reset: drive rst=0 for 1 clk at (400,300). Expect (0,0) next cycle, no frame_tick, and the next frame_tick 1,680,000 clk after release.
6. CLK_DIV=1 build: pix_en is high every clk after reset and low during reset. One line takes 800 clk.
